// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch (IF)
// and the load/store stage (MEM). Each 8/16/32-bit access is sequenced as
// consecutive little-endian byte transfers. MEM has fixed priority over IF.
// Per-stage stall requests stay high until the matching done pulse.
module mem_arbiter #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch side
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_inst,
  output logic              if_done,
  // Load/store side
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [1:0]        mem_width,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  // Byte-wide RAM port
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  // Stall requests to the stall controller
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Number of byte transfers for a width code; code 3 behaves as a word.
  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              owner_mem_q;   // 1: current transaction belongs to MEM
  logic [RAM_AW-1:0] base_q;        // latched base address, already truncated
  logic [31:0]       wdata_q;       // latched store data
  logic [2:0]        nbytes_q;      // transfer length of current transaction
  logic [2:0]        cnt_q;         // cycles spent in the current access state
  logic [31:0]       rd_buf_q;      // bytes gathered so far for a read

  logic [2:0]        cnt_next;
  logic [1:0]        cap_idx;
  logic [31:0]       rd_merged;
  logic [RAM_AW-1:0] next_addr;
  logic              accept_mem;
  logic              accept_if;
  logic              rd_end;
  logic              wr_end;

  // Address bits above the RAM window never reach the RAM; since the byte
  // offset is added modulo 2^32 and then truncated, adding in RAM_AW bits
  // gives the identical result.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

  assign cnt_next  = cnt_q + 3'd1;
  assign next_addr = base_q + RAM_AW'(cnt_next);

  // In a read state, cycle cnt (cnt >= 1) sees the byte addressed in cycle
  // cnt-1, so that byte lands in lane cnt-1.
  assign cap_idx   = cnt_q[1:0] - 2'd1;
  assign rd_merged = rd_buf_q | ({24'd0, ram_din} << {cap_idx, 3'b000});

  // Reads finish once the last byte has been captured; writes finish once
  // the last byte has been presented on the RAM port.
  assign rd_end = (cnt_q == nbytes_q);
  assign wr_end = (cnt_next == nbytes_q);

  // Requests are only sampled in IDLE; MEM wins, and a flush vetoes IF.
  assign accept_mem = (state_q == IDLE) && mem_req;
  assign accept_if  = (state_q == IDLE) && !mem_req && if_req && !if_flush;

  assign if_done      = (state_q == DONE) && !owner_mem_q;
  assign mem_done     = (state_q == DONE) &&  owner_mem_q;
  assign stallreq_if  = if_req  && !if_done;
  assign stallreq_mem = mem_req && !mem_done;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_mem)     state_d = mem_we ? MEM_WR : MEM_RD;
        else if (accept_if) state_d = IF_RD;
      end
      IF_RD: begin
        if (if_flush)    state_d = IDLE;
        else if (rd_end) state_d = DONE;
      end
      MEM_RD: begin
        if (rd_end) state_d = DONE;
      end
      MEM_WR: begin
        if (wr_end) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latching, RAM port sequencing and read-data assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_mem_q <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      rd_buf_q    <= '0;
      ram_addr    <= '0;
      ram_wr      <= 1'b0;
      ram_dout    <= '0;
      if_inst     <= '0;
      mem_rdata   <= '0;
    end else begin
      // The write strobe is only raised inside the store byte-issue window.
      ram_wr <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_mem) begin
            owner_mem_q <= 1'b1;
            base_q      <= mem_addr[RAM_AW-1:0];
            wdata_q     <= mem_wdata;
            nbytes_q    <= width_bytes(mem_width);
            cnt_q       <= '0;
            rd_buf_q    <= '0;
            ram_addr    <= mem_addr[RAM_AW-1:0];
            if (mem_we) begin
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
            end
          end else if (accept_if) begin
            owner_mem_q <= 1'b0;
            base_q      <= if_addr[RAM_AW-1:0];
            nbytes_q    <= 3'd4;
            cnt_q       <= '0;
            rd_buf_q    <= '0;
            ram_addr    <= if_addr[RAM_AW-1:0];
          end
        end
        IF_RD, MEM_RD: begin
          // A flushed fetch is dropped; partial bytes are discarded because
          // rd_buf_q is cleared at the next acceptance.
          if (!(state_q == IF_RD && if_flush)) begin
            cnt_q <= cnt_next;
            if (cnt_next < nbytes_q) ram_addr <= next_addr;
            if (cnt_q != 3'd0)       rd_buf_q <= rd_merged;
            if (rd_end) begin
              if (owner_mem_q) mem_rdata <= rd_merged;
              else             if_inst   <= rd_merged;
            end
          end
        end
        MEM_WR: begin
          cnt_q <= cnt_next;
          if (!wr_end) begin
            ram_addr <= next_addr;
            ram_wr   <= 1'b1;
            ram_dout <= wdata_q[{cnt_next[1:0], 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A byte-array RAM model serves the RAM
// port; a separate reference memory plus arithmetic on the access rules
// (byte count, little-endian lanes, cycle offsets from acceptance) provides
// every expected value.
module tb_mem_arbiter;

  localparam int RAM_AW   = 17;
  localparam int RAM_SIZE = 1 << RAM_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_flush, if_done;
  logic [31:0]       if_addr, if_inst;
  logic              mem_req, mem_we, mem_done;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [1:0]        mem_width;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout, ram_din;
  logic              stallreq_if, stallreq_mem;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ram     [0:RAM_SIZE-1];
  logic [7:0]  ref_mem [0:RAM_SIZE-1];
  bit          ram_ready = 1'b0;
  logic [31:0] exp_if_inst   = '0;
  logic [31:0] exp_mem_rdata = '0;

  mem_arbiter #(.RAM_AW(RAM_AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_flush     (if_flush),
    .if_inst      (if_inst),
    .if_done      (if_done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_width    (mem_width),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .ram_addr     (ram_addr),
    .ram_wr       (ram_wr),
    .ram_dout     (ram_dout),
    .ram_din      (ram_din),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem)
  );

  always #5 clk = ~clk;

  // Initial RAM image: a few fixed bytes used by the directed tests, a
  // deterministic pattern elsewhere.
  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h10:    return 8'h13;
      'h11:    return 8'h05;
      'h12:    return 8'h00;
      'h13:    return 8'h00;
      'h1FFFF: return 8'h34;
      'h0:     return 8'h12;
      default: return 8'(i * 37 + (i >> 7) * 11) ^ 8'h5A;
    endcase
  endfunction

  // RAM byte index of base+k: add modulo 2^32, keep the low RAM_AW bits.
  function automatic logic [RAM_AW-1:0] ra(input logic [31:0] base, input int k);
    logic [31:0] s;
    s = base + 32'(k);
    return s[RAM_AW-1:0];
  endfunction

  function automatic int nbytes_of(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  // RAM model: read data appears the cycle after its address; writes commit
  // at the clock edge.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < RAM_SIZE; i++) ram[i] = init_byte(i);
      ram_ready = 1'b1;
    end
    ram_din <= ram[ram_addr];
    if (ram_wr) ram[ram_addr] = ram_dout;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b1; if_flush = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_width = '0; mem_wdata = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({ram_addr, ram_wr, ram_dout} !== '0) begin n_err++;
      $display("FAIL reset_ram_port: got addr=%h wr=%b dout=%h expected all zero", ram_addr, ram_wr, ram_dout); end
    n_cmp++; if ({if_inst, mem_rdata} !== 64'd0) begin n_err++;
      $display("FAIL reset_data: got if_inst=%h mem_rdata=%h expected 0", if_inst, mem_rdata); end
    n_cmp++; if ({if_done, mem_done} !== 2'b00) begin n_err++;
      $display("FAIL reset_done: got %b%b expected 00", if_done, mem_done); end
    n_cmp++; if ({stallreq_if, stallreq_mem} !== 2'b10) begin n_err++;
      $display("FAIL reset_stallreq: got %b%b expected 10", stallreq_if, stallreq_mem); end
    next_cycle();
    rst = 1'b0; if_req = 1'b0;
  endtask

  // Checks one fetch whose request is already driven in the current
  // (IDLE) cycle A. Returns at posedge+1 of the cycle two after done.
  task automatic if_body(input logic [31:0] addr, input string tag);
    logic [31:0] exp_i;
    for (int i = 0; i < 4; i++) exp_i[8*i +: 8] = ref_mem[ra(addr, i)];
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++; if (if_done !== (k == 6)) begin n_err++;
        $display("FAIL %s if_done k=%0d: got %b expected %b", tag, k, if_done, k == 6); end
      n_cmp++; if (stallreq_if !== (k < 6)) begin n_err++;
        $display("FAIL %s stallreq_if k=%0d: got %b expected %b", tag, k, stallreq_if, k < 6); end
      n_cmp++; if (ram_wr !== 1'b0) begin n_err++;
        $display("FAIL %s ram_wr k=%0d: got %b expected 0", tag, k, ram_wr); end
      if (k >= 1 && k <= 4) begin
        n_cmp++; if (ram_addr !== ra(addr, k - 1)) begin n_err++;
          $display("FAIL %s ram_addr k=%0d: got %h expected %h", tag, k, ram_addr, ra(addr, k - 1)); end
      end
      if (k == 0) begin
        n_cmp++; if (if_inst !== exp_if_inst) begin n_err++;
          $display("FAIL %s if_inst_hold: got %h expected %h", tag, if_inst, exp_if_inst); end
      end
      if (k == 6) begin
        n_cmp++; if (if_inst !== exp_i) begin n_err++;
          $display("FAIL %s if_inst: got %h expected %h", tag, if_inst, exp_i); end
      end
      next_cycle();
    end
    if_req = 1'b0;
    exp_if_inst = exp_i;
    @(negedge clk);
    n_cmp++; if (if_done !== 1'b0) begin n_err++;
      $display("FAIL %s if_done_after: got %b expected 0", tag, if_done); end
    next_cycle();
  endtask

  task automatic run_if(input logic [31:0] addr, input string tag);
    if_req = 1'b1; if_addr = addr; if_flush = 1'b0;
    if_body(addr, tag);
  endtask

  task automatic run_mem(input logic we, input logic [1:0] width, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
    int n, exp_done;
    logic [31:0] exp_r;
    n = nbytes_of(width);
    exp_done = we ? n + 1 : n + 2;
    exp_r = '0;
    if (!we) for (int i = 0; i < n; i++) exp_r[8*i +: 8] = ref_mem[ra(addr, i)];
    mem_req = 1'b1; mem_we = we; mem_width = width; mem_addr = addr; mem_wdata = wdata;
    for (int k = 0; k <= exp_done; k++) begin
      @(negedge clk);
      n_cmp++; if (mem_done !== (k == exp_done)) begin n_err++;
        $display("FAIL %s mem_done k=%0d: got %b expected %b", tag, k, mem_done, k == exp_done); end
      n_cmp++; if (stallreq_mem !== (k < exp_done)) begin n_err++;
        $display("FAIL %s stallreq_mem k=%0d: got %b expected %b", tag, k, stallreq_mem, k < exp_done); end
      n_cmp++; if (ram_wr !== (we && k >= 1 && k <= n)) begin n_err++;
        $display("FAIL %s ram_wr k=%0d: got %b expected %b", tag, k, ram_wr, we && k >= 1 && k <= n); end
      if (k >= 1 && k <= n) begin
        n_cmp++; if (ram_addr !== ra(addr, k - 1)) begin n_err++;
          $display("FAIL %s ram_addr k=%0d: got %h expected %h", tag, k, ram_addr, ra(addr, k - 1)); end
        if (we) begin
          n_cmp++; if (ram_dout !== wdata[8*(k-1) +: 8]) begin n_err++;
            $display("FAIL %s ram_dout k=%0d: got %h expected %h", tag, k, ram_dout, wdata[8*(k-1) +: 8]); end
        end
      end
      if (k == exp_done) begin
        n_cmp++; if (mem_rdata !== (we ? exp_mem_rdata : exp_r)) begin n_err++;
          $display("FAIL %s mem_rdata: got %h expected %h", tag, mem_rdata, we ? exp_mem_rdata : exp_r); end
      end
      next_cycle();
    end
    mem_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_done, ram_wr} !== 2'b00) begin n_err++;
      $display("FAIL %s after_done: got done=%b wr=%b expected 0 0", tag, mem_done, ram_wr); end
    if (we) begin
      for (int i = 0; i < n; i++) begin
        ref_mem[ra(addr, i)] = wdata[8*i +: 8];
        n_cmp++; if (ram[ra(addr, i)] !== wdata[8*i +: 8]) begin n_err++;
          $display("FAIL %s ram_content[%0d]: got %h expected %h", tag, i, ram[ra(addr, i)], wdata[8*i +: 8]); end
      end
      if (n < 4) begin
        n_cmp++; if (ram[ra(addr, n)] !== ref_mem[ra(addr, n)]) begin n_err++;
          $display("FAIL %s ram_untouched: got %h expected %h", tag, ram[ra(addr, n)], ref_mem[ra(addr, n)]); end
      end
    end else begin
      exp_mem_rdata = exp_r;
    end
    next_cycle();
  endtask

  task automatic test_word_fetch;
    run_if(32'h10, "word_fetch");
    n_cmp++; if (exp_if_inst !== 32'h00000513) begin n_err++;
      $display("FAIL word_fetch_image: got %h expected 00000513", exp_if_inst); end
  endtask

  task automatic test_byte_store;
    run_mem(1'b1, 2'd0, 32'h20, 32'hDEADBEEF, "byte_store");
  endtask

  task automatic test_half_load_wrap;
    run_mem(1'b0, 2'd1, 32'h0001FFFF, '0, "half_wrap");
    n_cmp++; if (exp_mem_rdata !== 32'h00001234) begin n_err++;
      $display("FAIL half_wrap_value: got %h expected 00001234", exp_mem_rdata); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] exp_m, exp_i;
    for (int i = 0; i < 4; i++) begin
      exp_m[8*i +: 8] = ref_mem[ra(32'h100, i)];
      exp_i[8*i +: 8] = ref_mem[ra(32'h180, i)];
    end
    mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd2; mem_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h180; if_flush = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      n_cmp++; if (mem_done !== (k == 6)) begin n_err++;
        $display("FAIL simul mem_done k=%0d: got %b expected %b", k, mem_done, k == 6); end
      n_cmp++; if (if_done !== (k == 13)) begin n_err++;
        $display("FAIL simul if_done k=%0d: got %b expected %b", k, if_done, k == 13); end
      n_cmp++; if (stallreq_if !== (k < 13)) begin n_err++;
        $display("FAIL simul stallreq_if k=%0d: got %b expected %b", k, stallreq_if, k < 13); end
      if (k >= 1 && k <= 4) begin
        n_cmp++; if (ram_addr !== ra(32'h100, k - 1)) begin n_err++;
          $display("FAIL simul mem_addr k=%0d: got %h expected %h", k, ram_addr, ra(32'h100, k - 1)); end
      end
      if (k >= 8 && k <= 11) begin
        n_cmp++; if (ram_addr !== ra(32'h180, k - 8)) begin n_err++;
          $display("FAIL simul if_addr k=%0d: got %h expected %h", k, ram_addr, ra(32'h180, k - 8)); end
      end
      if (k == 6) begin
        n_cmp++; if (mem_rdata !== exp_m) begin n_err++;
          $display("FAIL simul mem_rdata: got %h expected %h", mem_rdata, exp_m); end
      end
      if (k == 13) begin
        n_cmp++; if (if_inst !== exp_i) begin n_err++;
          $display("FAIL simul if_inst: got %h expected %h", if_inst, exp_i); end
      end
      next_cycle();
      if (k == 6)  mem_req = 1'b0;
      if (k == 13) if_req  = 1'b0;
    end
    exp_mem_rdata = exp_m;
    exp_if_inst   = exp_i;
  endtask

  task automatic test_flush;
    if_req = 1'b1; if_addr = 32'h200; if_flush = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++; if (if_done !== 1'b0) begin n_err++;
        $display("FAIL flush if_done k=%0d: got %b expected 0", k, if_done); end
      if (k >= 1) begin
        n_cmp++; if (ram_addr !== ra(32'h200, k - 1)) begin n_err++;
          $display("FAIL flush ram_addr k=%0d: got %h expected %h", k, ram_addr, ra(32'h200, k - 1)); end
      end
      next_cycle();
      if (k == 2) if_flush = 1'b1;
    end
    // Cycle A+4: the arbiter is back in IDLE and takes the redirected fetch.
    if_flush = 1'b0;
    if_addr  = 32'h40;
    if_body(32'h40, "flush_refetch");
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] wd;
    wd = $urandom;
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'h400; mem_wdata = wd;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++; if (ram_wr !== (k >= 1)) begin n_err++;
        $display("FAIL rst_store ram_wr k=%0d: got %b expected %b", k, ram_wr, k >= 1); end
      n_cmp++; if (mem_done !== 1'b0) begin n_err++;
        $display("FAIL rst_store mem_done k=%0d: got %b expected 0", k, mem_done); end
      next_cycle();
      if (k == 1) rst = 1'b1;
    end
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    // Bytes 0 and 1 were presented in A+1 and A+2 before the reset edge.
    ref_mem[ra(32'h400, 0)] = wd[7:0];
    ref_mem[ra(32'h400, 1)] = wd[15:8];
    exp_if_inst = '0; exp_mem_rdata = '0;
    @(negedge clk);
    n_cmp++; if ({ram_addr, ram_wr, ram_dout, mem_done, if_done} !== '0) begin n_err++;
      $display("FAIL rst_store_port: got addr=%h wr=%b dout=%h done=%b%b expected all zero",
               ram_addr, ram_wr, ram_dout, mem_done, if_done); end
    n_cmp++; if ({if_inst, mem_rdata} !== 64'd0) begin n_err++;
      $display("FAIL rst_store_data: got if_inst=%h mem_rdata=%h expected 0", if_inst, mem_rdata); end
    next_cycle();
    run_mem(1'b0, 2'd2, 32'h400, '0, "rst_store_reload");
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 1) == 0) ? $urandom : (32'h300 + 32'($urandom_range(0, 15)));
      case ($urandom_range(0, 2))
        0:       run_if(a, "rand_fetch");
        1:       run_mem(1'b0, 2'($urandom_range(0, 3)), a, '0, "rand_load");
        default: run_mem(1'b1, 2'($urandom_range(0, 3)), a, $urandom, "rand_store");
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = init_byte(i);
    test_reset();
    test_word_fetch();
    test_byte_store();
    test_half_load_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid_store();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
